// File: rtl/booth_seq_mul_if.sv
// Operand/result handshake bundle for the sequential Booth multiplier.
// The operand source and the result sink both sit on the master side.
interface booth_seq_mul_if #(
   parameter int WIDTH = 11
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product
   );
endinterface

// File: rtl/booth_seq_mul.sv
// Iterative radix-4 Booth multiplier: one digit per clock into a 2*WIDTH
// accumulator, with valid/ready on operands and product.
module booth_seq_mul #(
   parameter int WIDTH = 11
) (
   input  logic                                clk,
   input  logic                                rst,
   booth_seq_mul_if.slave                      bus,
   output logic                                busy,
   output logic [$clog2((WIDTH+2)/2+1)-1:0]    digit_idx
);
   localparam int NDIG = (WIDTH + 2) / 2;
   localparam int IW   = $clog2(NDIG + 1);
   localparam int PW   = 2 * WIDTH;
   localparam int BW   = 2 * NDIG + 1;
   localparam int PAD  = 2 * NDIG - WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [PW-1:0] ONE = PW'(1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [BW-1:0]    b_q, b_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [PW-1:0]    prod_q, prod_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic [2:0]       trip;
   logic [PW-1:0]    a_ext, pp, pp_sh, acc_sum;
   logic             last;

   // b_q holds {zero pad, b, b[-1]=0} so digit i's triplet starts at bit 2i.
   assign trip    = b_q[{idx_q, 1'b0} +: 3];
   assign a_ext   = {{WIDTH{1'b0}}, a_q};
   assign pp_sh   = pp << {idx_q, 1'b0};
   assign acc_sum = acc_q + pp_sh;
   assign last    = (idx_q == IW'(NDIG - 1));

   always_comb begin
      pp = '0;
      case (trip)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = ~(a_ext << 1) + ONE;
         3'b101, 3'b110: pp = ~a_ext + ONE;
         default:        pp = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      prod_d  = prod_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = {{PAD{1'b0}}, bus.b, 1'b0};
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = acc_sum;
            idx_d = idx_q + IW'(1);
            if (last) begin
               prod_d  = acc_sum;
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.product   = prod_q;
   assign busy          = (state_q != S_IDLE);
   assign digit_idx     = idx_q;
endmodule

// File: tb/tb_booth_seq_mul.sv
// Directed bench for booth_seq_mul (WIDTH=11): vector table plus hand-written
// reset, backpressure and back-to-back sequences.
module tb_booth_seq_mul;
   localparam int W = 11;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       busy;
   logic [2:0] digit_idx;
   int         n_chk = 0;
   int         n_fail = 0;

   booth_seq_mul_if #(.WIDTH(W)) bus ();

   booth_seq_mul #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .digit_idx (digit_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p;
      int             hold;
   } vec_t;

   vec_t vt[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one pair, follow it through RUN, optionally stall, then release.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [2*W-1:0] exp, input string nm, input int hold);
      int cyc;
      bit idx_ok, busy_ok, stall_ok;
      bus.out_ready = (hold == 0);
      bus.a = ta;
      bus.b = tb_;
      bus.in_valid = 1'b1;
      chk({nm, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.a = ~ta;
      bus.b = ~tb_;
      cyc = 0;
      idx_ok = 1'b1;
      busy_ok = 1'b1;
      while (!bus.out_valid && cyc < 20) begin
         if (digit_idx != 3'(cyc)) idx_ok = 1'b0;
         if (!busy || bus.in_ready) busy_ok = 1'b0;
         tick();
         cyc++;
      end
      chk({nm, ".latency"}, 32'(cyc), 32'd6);
      chk({nm, ".product"}, 32'(bus.product), 32'(exp));
      chk({nm, ".digit_seq"}, 32'(idx_ok), 32'd1);
      chk({nm, ".busy_run"}, 32'(busy_ok), 32'd1);
      if (hold > 0) begin
         stall_ok = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            if (!bus.out_valid || bus.in_ready || !busy || bus.product !== exp)
               stall_ok = 1'b0;
         end
         chk({nm, ".stall_hold"}, 32'(stall_ok), 32'd1);
         bus.out_ready = 1'b1;
      end
      tick();
      chk({nm, ".in_ready_after"}, 32'(bus.in_ready), 32'd1);
      chk({nm, ".out_valid_after"}, 32'(bus.out_valid), 32'd0);
      chk({nm, ".product_kept"}, 32'(bus.product), 32'(exp));
   endtask

   initial begin
      int k;
      bit first_ok;
      vt[0] = '{a: 11'h7FF, b: 11'h7FF, p: 22'h3FF001, hold: 0};
      vt[1] = '{a: 11'h400, b: 11'h400, p: 22'h100000, hold: 0};
      vt[2] = '{a: 11'h000, b: 11'h7FF, p: 22'h0,      hold: 0};
      vt[3] = '{a: 11'h003, b: 11'h555, p: 22'hFFF,    hold: 0};
      vt[4] = '{a: 11'd5,   b: 11'd3,   p: 22'd15,     hold: 10};
      vt[5] = '{a: 11'h7FF, b: 11'h001, p: 22'h7FF,    hold: 0};
      vt[6] = '{a: 11'h001, b: 11'h7FF, p: 22'h7FF,    hold: 0};
      vt[7] = '{a: 11'h7FF, b: 11'h400, p: 22'h1FFC00, hold: 0};
      vt[8] = '{a: 11'h555, b: 11'h2AA, p: 22'd930930, hold: 2};

      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
      chk("reset.out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.product", 32'(bus.product), 32'd0);
      chk("reset.digit_idx", 32'(digit_idx), 32'd0);

      foreach (vt[i]) run_op(vt[i].a, vt[i].b, vt[i].p, $sformatf("v%0d", i), vt[i].hold);

      // Reset while digit 3 is in flight.
      bus.out_ready = 1'b1;
      bus.a = 11'h7FF;
      bus.b = 11'h7FF;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      k = 0;
      while (digit_idx != 3'd3 && k < 20) begin
         tick();
         k++;
      end
      chk("rstmid.reach_idx3", 32'(digit_idx), 32'd3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rstmid.in_ready", 32'(bus.in_ready), 32'd1);
      chk("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
      chk("rstmid.product", 32'(bus.product), 32'd0);
      chk("rstmid.busy", 32'(busy), 32'd0);
      chk("rstmid.digit_idx", 32'(digit_idx), 32'd0);
      run_op(11'd2, 11'd9, 22'd18, "after_rst", 0);

      // Back-to-back with in_valid held high.
      bus.out_ready = 1'b1;
      bus.a = 11'd100;
      bus.b = 11'd200;
      bus.in_valid = 1'b1;
      tick();
      bus.a = 11'd1023;
      bus.b = 11'd1;
      k = 0;
      first_ok = 1'b0;
      while (!bus.in_ready && k < 20) begin
         tick();
         k++;
         if (bus.out_valid && bus.product == 22'd20000) first_ok = 1'b1;
      end
      chk("b2b.first_product", 32'(first_ok), 32'd1);
      chk("b2b.accept_spacing", 32'(k + 1), 32'd8);
      tick();
      bus.in_valid = 1'b0;
      k = 0;
      while (!bus.out_valid && k < 20) begin
         tick();
         k++;
      end
      chk("b2b.second_latency", 32'(k), 32'd6);
      chk("b2b.second_product", 32'(bus.product), 32'd1023);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/booth_seq_mul.md
Name: booth_seq_mul

Overview:
- Iterative unsigned mantissa multiplier controller built on radix-4 Booth recoding.
- Retires one Booth digit per clock into a 2*WIDTH accumulator, reusing a single partial-product row instead of a full Dadda tree.
- Intended for the area-optimised FPMUL variant; sits where the partial-product generator and Dadda tree sit in the combinational multiplier.
- Uses valid/ready handshakes on both the operand side and the result side.

Parameters:
- WIDTH, 11, operand width in bits (unsigned mantissa including hidden bit); legal range 4..32.
- NDIG, (WIDTH+2)/2 (derived localparam, integer division), number of Booth digits; 6 for WIDTH=11.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned; Booth-recoded.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- product  out  2*WIDTH  unsigned a*b.
- busy  out  1  high in RUN or DONE.
- digit_idx  out  $clog2(NDIG+1)  index of the digit processed in the current RUN cycle; 0 outside RUN.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; in_ready=1, out_valid=0, busy=0, product=0, digit_idx=0; accumulator and operand registers cleared. Reset applies in any state and aborts an in-flight operation; that operation produces no result.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, busy=1.
  - DONE: in_ready=0, out_valid=1, busy=1.
- IDLE transitions: on an edge with in_valid=1, latch a and b, set acc=0 and digit_idx=0, go to RUN. Otherwise hold.
- RUN: each edge processes digit i=digit_idx.
  - Triplet is (b[2i+1], b[2i], b[2i-1]), with b[-1]=0 and b[k]=0 for k>=WIDTH (zero-extended unsigned).
  - Digit mapping: 000,111 -> 0; 001,010 -> +1; 011 -> +2; 100 -> -2; 101,110 -> -1.
  - Accumulator update: acc <= acc + ((digit*a) << 2i), computed modulo 2^(2*WIDTH) in two's complement. Negative digits use the inverted multiplicand plus one.
  - Digit index: digit_idx increments each edge.
  - Last digit: after the edge processing i=NDIG-1, product <= final acc and go to DONE.
- DONE: product and out_valid held stable while out_ready=0. On an edge with out_ready=1, go to IDLE, clear out_valid, and hold product at its last value.
- Timing:
  - Latency: out_valid rises exactly NDIG cycles after the acceptance edge (6 for WIDTH=11).
  - Throughput: one operation per NDIG+2 cycles when out_ready is held at 1.
  - Latency is fixed: zero digits are not skipped, so latency is independent of data.
- Simultaneous events: rst has priority over every handshake. in_valid during RUN or DONE is ignored, and the operands must be held by the source until in_ready.
- Result: the final product equals the exact unsigned a*b. It never overflows, because a*b < 2^(2*WIDTH).
- The a and b inputs are sampled only on the acceptance edge; later input changes do not affect the in-flight product.

Test Plan:
- Max operands: a=0x7FF, b=0x7FF, out_ready=1 -> out_valid 6 cycles after accept; product=0x3FF001 (4190209).
- Hidden-bit only: a=0x400, b=0x400 -> product=0x100000.
- Zeros and alternation:
  - a=0x000, b=0x7FF -> product=0.
  - a=0x003, b=0x555 -> product=0xFFF (4095); digit_idx steps 0..5 across RUN.
- Backpressure: a=5, b=3 with out_ready=0 for 10 cycles after out_valid -> product=15 held stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
- Reset mid-op: accept a=0x7FF, b=0x7FF, assert rst at digit_idx=3 -> next cycle IDLE, out_valid=0, product=0. A following a=2, b=9 yields 18 with normal latency.
- Back-to-back: in_valid held with a new pair each time in_ready=1 (e.g. 100*200, then 1023*1), out_ready=1 -> products 20000, then 1023; second accept exactly 8 cycles after the first.
